// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - direct-mapped instruction cache with byte-wide refill
// Looks up pc each cycle; on a miss assembles one word from four byte reads.
module inst_fetcher #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] inst,
  output logic        inst_ok,
  output logic [31:0] inst_pc
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [31:0] req_pc;
  logic [31:0] addr_q;
  logic [31:0] asm_buf;
  logic [2:0]  ic;
  logic [2:0]  rc;
  logic        pend;

  logic [INDEX_BITS-1:0] lk_idx, rq_idx;
  logic [TAG_BITS-1:0]   lk_tag, rq_tag;
  logic                  hit, abort, last_byte;

  assign lk_idx    = pc[INDEX_BITS+1:2];
  assign lk_tag    = pc[31:INDEX_BITS+2];
  assign rq_idx    = req_pc[INDEX_BITS+1:2];
  assign rq_tag    = req_pc[31:INDEX_BITS+2];
  assign hit       = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign abort     = (pc != req_pc);
  assign last_byte = pend && (rc == 3'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_req is gated by abort combinationally so a pc change drops it at once
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = addr_q;
    case (state)
      S_IDLE: begin
        if (!hit) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          if (ic < 3'd4) begin
            mem_req  = 1'b1;
            mem_addr = {req_pc[31:2], 2'b00} + {29'd0, ic};
          end
          if (last_byte) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= '0;
      inst    <= '0;
      inst_ok <= 1'b0;
      inst_pc <= '0;
      req_pc  <= '0;
      addr_q  <= '0;
      asm_buf <= '0;
      ic      <= '0;
      rc      <= '0;
      pend    <= 1'b0;
    end else begin
      pend <= mem_req && mem_gnt;
      if (mem_req) addr_q <= mem_addr;
      case (state)
        S_IDLE: begin
          inst_pc <= pc;
          if (hit) begin
            inst_ok <= 1'b1;
            inst    <= data_mem[lk_idx];
          end else begin
            inst_ok <= 1'b0;
            req_pc  <= pc;
            ic      <= '0;
            rc      <= '0;
          end
        end
        S_FETCH: begin
          // an aborted refill discards whatever byte is arriving
          if (!abort) begin
            if (mem_req && mem_gnt) ic <= ic + 3'd1;
            if (pend) begin
              asm_buf[{rc[1:0], 3'b000} +: 8] <= mem_din;
              rc <= rc + 3'd1;
            end
          end
        end
        S_DONE: begin
          valid[rq_idx] <= 1'b1;
          inst          <= asm_buf;
          inst_pc       <= req_pc;
          inst_ok       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DONE) begin
      tag_mem[rq_idx]  <= rq_tag;
      data_mem[rq_idx] <= asm_buf;
    end
  end

endmodule
